// File: rtl/video_timing_gen.sv
// Raster timing generator for the 1280x720@60 display pipeline.
// Produces pixel/line coordinates plus registered sync, active-draw,
// new-frame and frame-count outputs, all aligned to the shown coordinates.
module video_timing_gen #(
  parameter int unsigned ACTIVE_H = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned ACTIVE_V = 720,
  parameter int unsigned V_FRONT  = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned FPS      = 60
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  localparam int unsigned TOTAL_H = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned TOTAL_V = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;

  if (TOTAL_H > 2048 || TOTAL_V > 1024 || FPS > 64 || FPS == 0) begin : g_bad_cfg
    $error("video_timing_gen: TOTAL_H must be <= 2048, TOTAL_V <= 1024, 1 <= FPS <= 64");
  end

  localparam logic [10:0] H_LAST    = 11'(TOTAL_H - 1);
  localparam logic [9:0]  V_LAST    = 10'(TOTAL_V - 1);
  localparam logic [10:0] H_ACT     = 11'(ACTIVE_H);
  localparam logic [9:0]  V_ACT     = 10'(ACTIVE_V);
  localparam logic [10:0] HS_FIRST  = 11'(ACTIVE_H + H_FRONT);
  localparam logic [10:0] HS_LAST   = 11'(ACTIVE_H + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST  = 10'(ACTIVE_V + V_FRONT);
  localparam logic [9:0]  VS_LAST   = 10'(ACTIVE_V + V_FRONT + V_SYNC - 1);
  localparam logic [5:0]  FC_LAST   = 6'(FPS - 1);

  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        ad_nxt;
  logic        nf_nxt;
  logic [5:0]  fc_nxt;

  // Next coordinates: hcount free-runs, vcount advances on the hcount wrap.
  always_comb begin
    h_nxt = hcount_out + 11'd1;
    v_nxt = vcount_out;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      if (vcount_out == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = vcount_out + 10'd1;
      end
    end
  end

  // Flags decoded from the next coordinates so the registered flags line up
  // with the registered coordinates in the same cycle.
  always_comb begin
    ad_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_nxt = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    nf_nxt = (h_nxt == H_ACT) && (v_nxt == V_ACT);
    fc_nxt = fc_out;
    if (nf_nxt) begin
      fc_nxt = (fc_out == FC_LAST) ? '0 : fc_out + 6'd1;
    end
  end

  // Output registers; reset parks the raster on the last pixel of the frame
  // so the first edge after release lands on (0,0).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcount_out <= H_LAST;
      vcount_out <= V_LAST;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
    end else begin
      hcount_out <= h_nxt;
      vcount_out <= v_nxt;
      hs_out     <= hs_nxt;
      vs_out     <= vs_nxt;
      ad_out     <= ad_nxt;
      nf_out     <= nf_nxt;
      fc_out     <= fc_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 1280x720 instance and a reduced
// 22x11 instance run side by side against an arithmetic raster model.
module tb_video_timing_gen;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } exp_t;

  typedef struct {
    int t;
    int h;
    int v;
    bit hs;
    bit vs;
    bit ad;
    bit nf;
    int fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [10:0] b_h, s_h;
  logic [9:0]  b_v, s_v;
  logic        b_hs, b_vs, b_ad, b_nf, s_hs, s_vs, s_ad, s_nf;
  logic [5:0]  b_fc, s_fc;

  int    checks = 0;
  int    errors = 0;
  longint t = -1;
  int    nf_cnt = 0;

  always #5 clk = ~clk;

  video_timing_gen dut_big (
    .clk_in(clk), .rst_in(rst_n),
    .hcount_out(b_h), .vcount_out(b_v),
    .hs_out(b_hs), .vs_out(b_vs), .ad_out(b_ad), .nf_out(b_nf), .fc_out(b_fc)
  );

  video_timing_gen #(
    .ACTIVE_H(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .ACTIVE_V(8), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FPS(60)
  ) dut_small (
    .clk_in(clk), .rst_in(rst_n),
    .hcount_out(s_h), .vcount_out(s_v),
    .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc)
  );

  // Raster position from the count of edges since release (t = 0 is the
  // first edge); t < 0 means reset is held.
  function automatic exp_t model(input longint tt, input int ah, input int hf, input int hsw,
                                 input int hb, input int av, input int vf, input int vsw,
                                 input int vb, input int fps);
    exp_t e;
    longint th, tv, fr, tf, h, v, nfc;
    th = ah + hf + hsw + hb;
    tv = av + vf + vsw + vb;
    if (tt < 0) begin
      e.h = 11'(th - 1); e.v = 10'(tv - 1);
      e.hs = 0; e.vs = 0; e.ad = 0; e.nf = 0; e.fc = '0;
      return e;
    end
    fr  = th * tv;
    tf  = tt % fr;
    h   = tf % th;
    v   = tf / th;
    nfc = tt / fr + ((tf >= av * th + ah) ? 1 : 0);
    e.h  = 11'(h);
    e.v  = 10'(v);
    e.ad = (h < ah) && (v < av);
    e.hs = (h >= ah + hf) && (h < ah + hf + hsw);
    e.vs = (v >= av + vf) && (v < av + vf + vsw);
    e.nf = (h == ah) && (v == av);
    e.fc = 6'(nfc % fps);
    return e;
  endfunction

  function automatic exp_t model_big(input longint tt);
    return model(tt, 1280, 110, 40, 220, 720, 5, 5, 20, 60);
  endfunction

  function automatic exp_t model_small(input longint tt);
    return model(tt, 16, 2, 2, 2, 8, 1, 1, 1, 60);
  endfunction

  task automatic check_out(input string name, input exp_t e,
                           input logic [10:0] h, input logic [9:0] v,
                           input logic hs, input logic vs, input logic ad,
                           input logic nf, input logic [5:0] fc);
    checks++;
    if (h !== e.h || v !== e.v || hs !== e.hs || vs !== e.vs ||
        ad !== e.ad || nf !== e.nf || fc !== e.fc) begin
      errors++;
      $display("FAIL %s t=%0d: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
               name, t, h, v, hs, vs, ad, nf, fc, e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_both(input string tag);
    check_out({tag, "_big"}, model_big(t), b_h, b_v, b_hs, b_vs, b_ad, b_nf, b_fc);
    check_out({tag, "_small"}, model_small(t), s_h, s_v, s_hs, s_vs, s_ad, s_nf, s_fc);
  endtask

  // One clock: advance the edge count, sample at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) t++;
    @(negedge clk);
    if (s_nf) nf_cnt++;
    check_both("model");
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t = -1;
    nf_cnt = 0;
  endtask

  // Reset dropped between edges must take effect without a clock.
  task automatic async_reset(input int dly, input int hold);
    @(negedge clk);
    #(dly);
    rst_n = 1'b0;
    t = -1;
    #1;
    check_both("async_rst");
    repeat (hold) step();
    release_reset();
  endtask

  function automatic exp_t from_vec(input vec_t r);
    exp_t e;
    e.h = 11'(r.h); e.v = 10'(r.v);
    e.hs = r.hs; e.vs = r.vs; e.ad = r.ad; e.nf = r.nf; e.fc = 6'(r.fc);
    return e;
  endfunction

  vec_t tab_s[18];
  vec_t tab_b[8];

  initial begin
    int bound;
    //               t    h    v   hs vs ad nf fc
    tab_s[0]  = '{  0,   0,   0,  0, 0, 1, 0, 0};
    tab_s[1]  = '{ 15,  15,   0,  0, 0, 1, 0, 0};
    tab_s[2]  = '{ 16,  16,   0,  0, 0, 0, 0, 0};
    tab_s[3]  = '{ 17,  17,   0,  0, 0, 0, 0, 0};
    tab_s[4]  = '{ 18,  18,   0,  1, 0, 0, 0, 0};
    tab_s[5]  = '{ 19,  19,   0,  1, 0, 0, 0, 0};
    tab_s[6]  = '{ 20,  20,   0,  0, 0, 0, 0, 0};
    tab_s[7]  = '{ 21,  21,   0,  0, 0, 0, 0, 0};
    tab_s[8]  = '{ 22,   0,   1,  0, 0, 1, 0, 0};
    tab_s[9]  = '{191,  15,   8,  0, 0, 0, 0, 0};
    tab_s[10] = '{192,  16,   8,  0, 0, 0, 1, 1};
    tab_s[11] = '{193,  17,   8,  0, 0, 0, 0, 1};
    tab_s[12] = '{198,   0,   9,  0, 1, 0, 0, 1};
    tab_s[13] = '{219,  21,   9,  0, 1, 0, 0, 1};
    tab_s[14] = '{220,   0,  10,  0, 0, 0, 0, 1};
    tab_s[15] = '{241,  21,  10,  0, 0, 0, 0, 1};
    tab_s[16] = '{242,   0,   0,  0, 0, 1, 0, 1};
    tab_s[17] = '{434,  16,   8,  0, 0, 0, 1, 2};

    tab_b[0]  = '{1279, 1279, 0,  0, 0, 1, 0, 0};
    tab_b[1]  = '{1280, 1280, 0,  0, 0, 0, 0, 0};
    tab_b[2]  = '{1389, 1389, 0,  0, 0, 0, 0, 0};
    tab_b[3]  = '{1390, 1390, 0,  1, 0, 0, 0, 0};
    tab_b[4]  = '{1429, 1429, 0,  1, 0, 0, 0, 0};
    tab_b[5]  = '{1430, 1430, 0,  0, 0, 0, 0, 0};
    tab_b[6]  = '{1649, 1649, 0,  0, 0, 0, 0, 0};
    tab_b[7]  = '{1650,    0, 1,  0, 0, 1, 0, 0};

    // Reset held for 10 cycles, then release.
    @(negedge clk);
    check_out("rst_small", from_vec('{-1, 21, 10, 0, 0, 0, 0, 0}),
              s_h, s_v, s_hs, s_vs, s_ad, s_nf, s_fc);
    check_out("rst_big", from_vec('{-1, 1649, 749, 0, 0, 0, 0, 0}),
              b_h, b_v, b_hs, b_vs, b_ad, b_nf, b_fc);
    repeat (10) step();
    release_reset();

    // Reduced-geometry vectors.
    foreach (tab_s[i]) begin
      while (t < tab_s[i].t) step();
      check_out($sformatf("vec_small_%0d", i), from_vec(tab_s[i]),
                s_h, s_v, s_hs, s_vs, s_ad, s_nf, s_fc);
    end

    // Full-size single line and first wrap.
    foreach (tab_b[i]) begin
      while (t < tab_b[i].t) step();
      check_out($sformatf("vec_big_%0d", i), from_vec(tab_b[i]),
                b_h, b_v, b_hs, b_vs, b_ad, b_nf, b_fc);
    end

    // 61 reduced frames: fc wraps 59 -> 0 on the 60th pulse, 1 on the 61st.
    while (t < 242 * 61) begin
      step();
      if (s_nf && nf_cnt == 59) check_int("fc_at_nf59", int'(s_fc), 59);
      if (s_nf && nf_cnt == 60) check_int("fc_at_nf60", int'(s_fc), 0);
      if (s_nf && nf_cnt == 61) check_int("fc_at_nf61", int'(s_fc), 1);
    end
    check_int("nf_pulses_61_frames", nf_cnt, 61);

    // Mid-vsync asynchronous reset on the reduced instance at (7,9).
    bound = 0;
    while (!(s_h == 11'd7 && s_v == 10'd9) && bound < 300) begin
      step();
      bound++;
    end
    check_int("reach_vs_line", bound < 300 ? 1 : 0, 1);
    check_int("vs_before_rst", int'(s_vs), 1);
    async_reset(2, 3);
    step();
    check_out("restart_small", from_vec('{0, 0, 0, 0, 0, 1, 0, 0}),
              s_h, s_v, s_hs, s_vs, s_ad, s_nf, s_fc);

    // Random run lengths interleaved with random asynchronous resets.
    for (int k = 0; k < 15; k++) begin
      int n;
      n = int'($urandom_range(1, 700));
      repeat (n) step();
      async_reset(int'($urandom_range(1, 3)), int'($urandom_range(1, 5)));
    end
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
